// File: rtl/zigzag_wr_buf.sv
// zigzag_wr_buf: ping-pong write buffer that gathers raster-order 8x8 coefficient blocks for a zigzag reader.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   raster-order write stream, in_data carries one coefficient
//   rd_start            one-cycle pulse when a full bank is handed to the reader
//   rd_done             reader finished the current bank
//   rd_en/rd_addr       reader address request (row*COL+col)
//   rd_data/_valid      registered read data, one cycle after rd_en
//   err                 sticky protocol error (rd_done or rd_en while no bank is handed out)
module zigzag_wr_buf #(
    parameter int WIDTH = 16,
    parameter int COL = 8,
    parameter int ROW = 8,
    localparam int AW = $clog2(COL) + $clog2(ROW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             rd_start,
    input  logic             rd_done,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_data_valid,
    output logic             err
);
    logic [WIDTH-1:0] mem [2*COL*ROW];
    logic             wr_bank_q, rd_bank_q, rd_busy_q, rd_start_q, rd_data_valid_q, err_q;
    logic [1:0]       full_q, full_d;
    logic [AW-1:0]    wr_cnt_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             wr_fire, wr_wrap, rd_fire, start;

    assign in_ready      = !full_q[wr_bank_q];
    assign rd_start      = rd_start_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign err           = err_q;

    always_comb begin
        wr_fire = in_valid && in_ready;
        // COL*ROW is a power of two, so the last slot is the all-ones count
        wr_wrap = wr_fire && (&wr_cnt_q);
        rd_fire = rd_done && rd_busy_q;
        start   = full_q[rd_bank_q] && !rd_busy_q && !rd_start_q;
        // writer and reader always own different banks, so both updates can apply together
        full_d  = (full_q | ({1'b0, wr_wrap} << wr_bank_q)) & ~({1'b0, rd_fire} << rd_bank_q);
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[{wr_bank_q, wr_cnt_q}] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            full_q          <= 2'b00;
            rd_busy_q       <= 1'b0;
            wr_cnt_q        <= '0;
            rd_start_q      <= 1'b0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            full_q          <= full_d;
            wr_cnt_q        <= wr_fire ? wr_cnt_q + AW'(1) : wr_cnt_q;
            wr_bank_q       <= wr_bank_q ^ wr_wrap;
            rd_bank_q       <= rd_bank_q ^ rd_fire;
            rd_busy_q       <= start || (rd_busy_q && !rd_fire);
            rd_start_q      <= start;
            rd_data_valid_q <= rd_en;
            if (rd_en) rd_data_q <= mem[{rd_bank_q, rd_addr}];
            err_q           <= err_q || (!rd_busy_q && (rd_done || rd_en));
        end
    end
endmodule

// File: tb/tb_zigzag_wr_buf.sv
// tb_zigzag_wr_buf: directed self-checking bench for zigzag_wr_buf.
module tb_zigzag_wr_buf;
    localparam int WIDTH = 16;
    localparam int AW = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             rd_start;
    logic             rd_done = 1'b0;
    logic             rd_en = 1'b0;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_data_valid;
    logic             err;

    int n_chk = 0;
    int n_fail = 0;
    int starts = 0;
    int zz [64];

    zigzag_wr_buf #(.WIDTH(WIDTH), .COL(8), .ROW(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .rd_start(rd_start),
        .rd_done(rd_done),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_start === 1'b1) starts++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr_n(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data = WIDTH'(base + i);
            chk("wr_ready", in_ready, 1);
            cyc();
        end
        in_valid = 1'b0;
    endtask

    task automatic rd1(input int addr, input int exp);
        rd_en = 1'b1;
        rd_addr = AW'(addr);
        cyc();
        rd_en = 1'b0;
        chk("rd_data", rd_data, exp);
        chk("rd_valid", rd_data_valid, 1);
    endtask

    task automatic done_pulse();
        rd_done = 1'b1;
        cyc();
        rd_done = 1'b0;
    endtask

    initial begin
        int k, wi, ri, rblk, rph, s0, exp_rd, lo, hi;
        logic acc;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            lo = s > 7 ? s - 7 : 0;
            hi = s < 7 ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
        // reset state
        cyc();
        cyc();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rd_start", rd_start, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_data_valid, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        // single block, zigzag read-out
        wr_n(0, 64);
        chk("t1_start_early", rd_start, 0);
        chk("t1_no_start_yet", starts, 0);
        cyc();
        chk("t1_start", rd_start, 1);
        cyc();
        chk("t1_start_pulse", rd_start, 0);
        for (int i = 0; i < 64; i++) rd1(zz[i], zz[i]);
        cyc();
        chk("t1_valid_drop", rd_data_valid, 0);
        chk("t1_data_hold", rd_data, 63);
        done_pulse();
        chk("t1_err", err, 0);
        chk("t1_starts", starts, 1);
        // back-to-back: three blocks with an always-ready reader
        wi = 0;
        ri = 0;
        rblk = 0;
        rph = 0;
        for (int c = 0; c < 400 && rblk < 3; c++) begin
            in_valid = wi < 192;
            in_data = WIDTH'(wi);
            rd_en = rph == 1;
            rd_addr = AW'(zz[ri & 63]);
            rd_done = rph == 2;
            chk("b2b_in_ready", in_ready, (wi / 64 - rblk) < 2);
            acc = in_valid && in_ready;
            exp_rd = rblk * 64 + zz[ri & 63];
            cyc();
            if (acc) wi++;
            if (rph == 1) begin
                chk("b2b_rd_data", rd_data, exp_rd);
                ri++;
                if (ri == 64) rph = 2;
            end else if (rph == 2) begin
                rph = 0;
                rblk++;
            end else if (rd_start === 1'b1) begin
                rph = 1;
                ri = 0;
            end
        end
        in_valid = 1'b0;
        rd_en = 1'b0;
        rd_done = 1'b0;
        chk("b2b_writes", wi, 192);
        chk("b2b_blocks", rblk, 3);
        chk("b2b_starts", starts, 4);
        chk("b2b_err", err, 0);
        // backpressure: both banks full, reader holds off
        wr_n(1000, 64);
        wr_n(1064, 64);
        chk("bp_full", in_ready, 0);
        in_valid = 1'b1;
        in_data = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold", in_ready, 0);
        end
        rd1(0, 1000);
        in_data = 16'd2000;
        rd_done = 1'b1;
        cyc();
        rd_done = 1'b0;
        chk("bp_release", in_ready, 1);
        wr_n(2000, 64);
        chk("bp_full2", in_ready, 0);
        rd1(5, 1069);
        done_pulse();
        cyc();
        chk("bp_start_bank0", rd_start, 1);
        rd1(0, 2000);
        rd1(63, 2063);
        // last write of bank 1 and rd_done of bank 0 on the same edge
        wr_n(3000, 63);
        in_valid = 1'b1;
        in_data = 16'd3063;
        rd_done = 1'b1;
        chk("sim_ready_last", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        rd_done = 1'b0;
        chk("sim_no_start", rd_start, 0);
        chk("sim_ready_bank0", in_ready, 1);
        cyc();
        chk("sim_start_bank1", rd_start, 1);
        rd1(63, 3063);
        rd1(0, 3000);
        in_valid = 1'b1;
        in_data = 16'd4000;
        chk("sim_wr_bank0", in_ready, 1);
        cyc();
        in_valid = 1'b0;
        done_pulse();
        chk("sim_err", err, 0);
        // reset in the middle of a block
        wr_n(5000, 30);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_rd_start", rd_start, 0);
        chk("mid_rst_valid", rd_data_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_ready", in_ready, 1);
        rst_n = 1'b1;
        s0 = starts;
        wr_n(6000, 64);
        chk("mid_rst_no_start", starts, s0);
        chk("mid_rst_start_early", rd_start, 0);
        cyc();
        chk("mid_rst_start", rd_start, 1);
        cyc();
        rd1(0, 6000);
        rd1(63, 6063);
        done_pulse();
        // protocol error: rd_done while idle
        chk("pe_err_before", err, 0);
        done_pulse();
        chk("pe_err_set", err, 1);
        cyc();
        cyc();
        chk("pe_err_sticky", err, 1);
        chk("pe_no_start", rd_start, 0);
        wr_n(7000, 64);
        cyc();
        chk("pe_start_bank1", rd_start, 1);
        rd1(10, 7010);
        done_pulse();
        chk("pe_err_kept", err, 1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("pe_err_cleared", err, 0);
        // rd_en while idle flags err but still returns data
        rd_en = 1'b1;
        rd_addr = '0;
        cyc();
        rd_en = 1'b0;
        chk("pe_rden_err", err, 1);
        chk("pe_rden_valid", rd_data_valid, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/zigzag_wr_buf.md
# zigzag_wr_buf

Write side of the zigzag reorder buffer. Accepts 8x8 coefficient blocks as a raster-order valid/ready stream and stores them in an internal two-bank (ping-pong) memory. When a bank is full, it issues a one-cycle `rd_start` to the zigzag read-address generator. It serves that generator's 6-bit addresses from the full bank until the generator returns `done`, then releases the bank for writing.

## Interface

Parameters:
- `WIDTH`, 16, coefficient width in bits.
- `COL`, 8, block columns (power of two).
- `ROW`, 8, block rows (power of two).
- `AW` (derived): `$clog2(COL)+$clog2(ROW)` = 6, the in-bank address width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  write data valid.
- `in_ready`  out  1  buffer can accept; combinational `!full[wr_bank]`.
- `in_data`  in  WIDTH  coefficient, raster order (row-major, col fastest).
- `rd_start`  out  1  one-cycle pulse: a full bank is available to the reader.
- `rd_done`  in  1  reader finished the current bank (single-cycle pulse).
- `rd_en`  in  1  read request (reader's `valid`).
- `rd_addr`  in  AW  in-bank address from the reader (`row*COL+col`).
- `rd_data`  out  WIDTH  registered read data.
- `rd_data_valid`  out  1  `rd_en` delayed one cycle.
- `err`  out  1  sticky protocol-error flag.

## Operation

State:
- `wr_bank`, `rd_bank` (1 bit each).
- `full[1:0]`.
- `rd_busy`.
- `wr_cnt` (AW bits).
- Memory: 2×COL×ROW words, indexed by `{bank, addr}`.

Write path:
- A write occurs when `in_valid && in_ready`: store `mem[{wr_bank, wr_cnt}] <= in_data`, then `wr_cnt++`.
- When `wr_cnt == COL*ROW-1` and a write occurs:
  - `full[wr_bank] <= 1`
  - `wr_bank <= ~wr_bank`
  - `wr_cnt <= 0` (natural wrap)

Read path:
- Start condition: `full[rd_bank] && !rd_busy && !rd_start`. On that condition, set `rd_start <= 1` and `rd_busy <= 1`. Otherwise `rd_start <= 0`.
- Sampled `rd_done` while `rd_busy`:
  - `full[rd_bank] <= 0`
  - `rd_bank <= ~rd_bank`
  - `rd_busy <= 0`
- `rd_done` while `!rd_busy`: ignored; sets `err <= 1`.
- Reads:
  - `rd_data <= mem[{rd_bank, rd_addr}]` whenever `rd_en`; `rd_data` holds otherwise.
  - `rd_data_valid <= rd_en`.
  - `rd_en` while `!rd_busy` sets `err` (the data is still returned).

Bank exclusivity:
- The writer only uses a bank with `full == 0`; the reader only uses a bank with `full == 1`. So both paths never touch the same bank.
- Setting `full[wr_bank]` and clearing `full[rd_bank]` in the same cycle always targets different banks. Both updates take effect.

Reset (`rd_n == 0` at a clock edge):
- Cleared to 0: `wr_bank`, `rd_bank`, `full`, `rd_busy`, `wr_cnt`, `rd_start`, `rd_data`, `rd_data_valid`, `err`.
- Memory contents are not reset.
- Reset mid-block discards the partial block and any full banks.
- After reset, `in_ready = 1`.

## Timing

- Write: 0-cycle acceptance. `in_ready` is combinational from registered `full`/`wr_bank`.
- Last write sampled at edge N:
  - `full` set after N.
  - `rd_start` high for the cycle after edge N+1 (latency 2 edges, 1-cycle pulse).
  - `in_ready` for the next block is valid immediately after N (the other bank, if empty).
- `rd_done` at edge M:
  - Bank freed after M.
  - If the other bank is already full, the next `rd_start` is registered at edge M+1.
- A bank filled while the reader is busy is started only after `rd_done`.
- Backpressure: with both banks full, `in_ready = 0` until the first `rd_done` edge. `in_ready` rises in the cycle after that edge.
- Read latency: exactly 1 cycle, `rd_addr`/`rd_en` at edge K → `rd_data`/`rd_data_valid` after K.
- Throughput: one write and one read per cycle, simultaneously.

## Test plan

- Single block: write values 0..63 in raster order, then the reader walks zigzag addresses 0,1,8,16,9,2,…
  - One `rd_start` pulse two edges after the last write.
  - `rd_data` equals `rd_addr` one cycle after each `rd_en`.
  - `err = 0`.
- Back-to-back: stream 3 blocks continuously (block b holds `b*64+i`) with the reader always ready.
  - `in_ready` drops only during the interval when both banks are full.
  - Each `rd_start` reads the correct bank.
  - No value is lost or duplicated.
- Backpressure: fill both banks with the reader held off (no `rd_done`).
  - `in_ready = 0` after 128 writes.
  - A 129th `in_valid` is not accepted.
  - `rd_done` → `in_ready = 1` the next cycle; the new write lands in bank 0.
- Simultaneous events: last write of bank 1 and `rd_done` for bank 0 on the same edge.
  - `full == 2'b10`.
  - `rd_start` fires the next cycle for bank 1.
  - Writer continues into bank 0.
- Reset mid-operation: assert `rst_n = 0` after 30 writes, then release.
  - All outputs are 0.
  - `in_ready = 1`.
  - The next 64 writes form block 0; no `rd_start` occurs before those 64 writes.
- Protocol error: pulse `rd_done` while idle.
  - `err` goes to 1 and stays 1 until reset.
  - `full`/`rd_bank` are unchanged.
